// File: rtl/seq_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response plus the decode-side
// instruction handshake. The fetch stage is the master; memory and decode sit on the slave side.
interface seq_fetch_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req_valid;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_req_ready;
  logic              imem_resp_valid;
  logic [31:0]       imem_resp_data;

  logic              inst_valid;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_ready;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    output inst_valid, inst_data, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    input  inst_valid, inst_data, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/seq_fetch.sv
// Sequential-core fetch stage: one outstanding imem request, a small instruction FIFO,
// and redirect flushes. SEQ_FETCH_MISALIGN_TRAP_EN adds a misaligned-redirect trap and HALT state.
module seq_fetch #(
  parameter int                 ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  seq_fetch_if.master       bus,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_misalign
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
`ifdef SEQ_FETCH_MISALIGN_TRAP_EN
    , HALT
`endif
  } state_t;

  state_t state_q, state_d, resume_st;

  logic [ADDR_W-1:0] pc_q, pc_d, req_pc_q, redirect_target;
  logic [31:0]       data_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept, push, pop, flush;

  // Outputs are gated by rst so nothing is presented while reset is held.
  assign bus.imem_req_valid = !rst && (state_q == REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = !rst && (count_q != '0);
  assign bus.inst_data      = data_mem[rd_ptr_q];
  assign bus.inst_pc        = pc_mem[rd_ptr_q];

  assign accept = bus.imem_req_valid && bus.imem_req_ready;
  assign pop    = bus.inst_valid && bus.inst_ready;
  assign flush  = redirect_valid;
  // A response arriving with a redirect belongs to the old stream and is dropped.
  assign push   = (state_q == WAIT) && bus.imem_resp_valid && !redirect_valid;

  assign redirect_target = {redirect_pc[ADDR_W-1:2], 2'b00};

`ifdef SEQ_FETCH_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  assign misalign_d     = redirect_valid ? (redirect_pc[1:0] != 2'b00) : misalign_q;
  assign resume_st      = misalign_d ? HALT : REQ;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign resume_st            = REQ;
  assign fetch_misalign       = 1'b0;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (flush)       pc_d = redirect_target;
    else if (accept) pc_d = pc_q + ADDR_W'(4);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ: begin
        // An accepted request is outstanding even if a redirect lands with it.
        if (redirect_valid) state_d = accept ? DRAIN : resume_st;
        else if (accept)    state_d = WAIT;
      end
      WAIT: begin
        if (redirect_valid)           state_d = bus.imem_resp_valid ? resume_st : DRAIN;
        else if (bus.imem_resp_valid) state_d = (count_d < CNT_FULL) ? REQ : IDLE;
      end
      IDLE: begin
        if (redirect_valid) state_d = resume_st;
        else if (pop)       state_d = REQ;
      end
      DRAIN: begin
        // Redirects keep draining; only the stale response ends this state.
        if (bus.imem_resp_valid) state_d = resume_st;
      end
`ifdef SEQ_FETCH_MISALIGN_TRAP_EN
      HALT: begin
        if (redirect_valid) state_d = resume_st;
      end
`endif
      default: state_d = REQ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= REQ;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      if (accept) req_pc_q <= pc_q;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

  // NOTE: FIFO storage is not reset; count_q alone decides which entries are
  // live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q] <= bus.imem_resp_data;
      pc_mem[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule
